// File: rtl/fwft_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fwft_wr_arbiter                                            |
// | Description : Round-robin arbiter that lets N_REQ word writers share     |
// |               one 32-bit-in / 8-bit-out first-word-fall-through byte     |
// |               FIFO. It owns the FIFO occupancy count and drives both     |
// |               the FIFO write strobe (one word = 4 bytes) and the read    |
// |               strobe (one byte per consumer pop). The FIFO itself holds  |
// |               only storage and pointers.                                 |
// |                                                                          |
// | Ports       : clk, rst_n        clock, async active-low reset            |
// |               req, req_data     per-requester request and 32-bit word    |
// |               gnt               registered one-hot one-cycle grant       |
// |               fifo_wr_en/_data  registered FIFO write strobe and word    |
// |               fifo_rd_en        comb FIFO read-pointer advance           |
// |               cons_rd           consumer pops the head byte              |
// |               cons_valid        comb, head byte valid (occupancy != 0)   |
// |               level, low_wm     occupancy and low-watermark flag, only   |
// |                                 when FWFT_ARB_LEVEL_EN is defined        |
// |                                                                          |
// | Options     : FWFT_ARB_LEVEL_EN adds the level/low_wm outputs.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fwft_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DEPTH  = 8,
    parameter int LOW_WM = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [32*N_REQ-1:0]     req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    fifo_wr_en,
    output logic [31:0]             fifo_wr_data,
    output logic                    fifo_rd_en,
    input  logic                    cons_rd,
    output logic                    cons_valid
`ifdef FWFT_ARB_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    low_wm
`endif
);

    localparam int c_cw  = $clog2(DEPTH) + 1;
    localparam int c_pw  = $clog2(N_REQ);
    localparam int c_pw1 = c_pw + 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_write = 2'd1;
    localparam logic [1:0] c_st_stall = 2'd2;

    // Reject parameter sets the arbiter was not built for.
    generate
        if (N_REQ < 2 || N_REQ > 8 || DEPTH < 4 ||
            (DEPTH & (DEPTH - 1)) != 0 || LOW_WM > DEPTH) begin : g_param_check
            $error("fwft_wr_arbiter: unsupported parameter set");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic             r_wr_en;
    logic [31:0]      r_wr_data;
    logic [c_pw-1:0]  r_rr_ptr;
    logic [c_cw-1:0]  r_occ;

    logic             w_any;
    logic             w_space;
    logic             w_grant;
    logic             w_hit;
    logic [c_pw-1:0]  w_win;
    logic [c_pw-1:0]  w_idx;
    logic [c_pw:0]    w_sum;
    logic [c_pw-1:0]  w_next_ptr;
    logic [c_cw-1:0]  w_add;
    logic [c_cw-1:0]  w_sub;
    logic [31:0]      w_words [N_REQ];

    // Unpack the flat word bus so it can be indexed by requester number.
    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_words[g] = req_data[32*g +: 32];
        end
    endgenerate

    assign w_any   = |req;
    // Space is judged on the current occupancy; a same-cycle pop does not help.
    assign w_space = (r_occ <= c_cw'(DEPTH - 4));
    assign w_grant = w_any && w_space &&
                     ((r_state == c_st_idle) || (r_state == c_st_stall));

    // Round-robin search starting at r_rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_hit = 1'b0;
        w_win = '0;
        w_sum = '0;
        w_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + c_pw1'(k);
            if (w_sum >= c_pw1'(N_REQ)) begin
                w_sum = w_sum - c_pw1'(N_REQ);
            end
            w_idx = w_sum[c_pw-1:0];
            if (!w_hit && req[w_idx]) begin
                w_hit = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_next_ptr = (w_win == c_pw'(N_REQ - 1)) ? '0 : w_win + c_pw'(1);

    // Arbitration FSM. gnt and fifo_wr_en default low so that they pulse
    // for exactly the WRITE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_gnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_gnt   <= '0;
            r_wr_en <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_state <= w_space ? c_st_write : c_st_stall;
                    end
                end
                c_st_write: begin
                    r_state <= c_st_idle;
                end
                c_st_stall: begin
                    if (!w_any) begin
                        r_state <= c_st_idle;
                    end else if (w_space) begin
                        r_state <= c_st_write;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
            if (w_grant) begin
                r_gnt     <= N_REQ'(1) << w_win;
                r_wr_en   <= 1'b1;
                r_wr_data <= w_words[w_win];
                r_rr_ptr  <= w_next_ptr;
            end
        end
    end

    // Occupancy: a word write adds 4 bytes, a pop removes 1; both may apply.
    assign w_add = r_wr_en    ? c_cw'(4) : '0;
    assign w_sub = fifo_rd_en ? c_cw'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + w_add - w_sub;
        end
    end

    assign gnt          = r_gnt;
    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign cons_valid   = (r_occ != '0);
    // Gating with cons_valid makes a pop on an empty FIFO a no-op.
    assign fifo_rd_en   = cons_rd & cons_valid;

`ifdef FWFT_ARB_LEVEL_EN
    assign level  = r_occ;
    assign low_wm = (r_occ <= c_cw'(LOW_WM));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwft_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fwft_wr_arbiter                                         |
// | Description : Directed self-checking bench for fwft_wr_arbiter with      |
// |               N_REQ=4, DEPTH=8, LOW_WM=2.                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_fwft_wr_arbiter;

    localparam int N_REQ  = 4;
    localparam int DEPTH  = 8;
    localparam int LOW_WM = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    gnt;
    logic                fifo_wr_en;
    logic [31:0]         fifo_wr_data;
    logic                fifo_rd_en;
    logic                cons_rd;
    logic                cons_valid;
`ifdef FWFT_ARB_LEVEL_EN
    logic [CW-1:0]       level;
    logic                low_wm;
`endif

    int checks = 0;
    int errors = 0;

    fwft_wr_arbiter #(
        .N_REQ  (N_REQ),
        .DEPTH  (DEPTH),
        .LOW_WM (LOW_WM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_rd_en   (fifo_rd_en),
        .cons_rd      (cons_rd),
        .cons_valid   (cons_valid)
`ifdef FWFT_ARB_LEVEL_EN
        ,
        .level        (level),
        .low_wm       (low_wm)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        cons_rd  = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_gnt",        64'(gnt),           64'h0);
        chk("rst_wr_en",      64'(fifo_wr_en),    64'h0);
        chk("rst_wr_data",    64'(fifo_wr_data),  64'h0);
        chk("rst_cons_valid", 64'(cons_valid),    64'h0);
        chk("rst_rd_en",      64'(fifo_rd_en),    64'h0);
        chk("rst_occ",        64'(dut.r_occ),     64'h0);
        chk("rst_rr_ptr",     64'(dut.r_rr_ptr),  64'h0);
`ifdef FWFT_ARB_LEVEL_EN
        chk("rst_level",      64'(level),         64'h0);
        chk("rst_low_wm",     64'(low_wm),        64'h1);
`endif
        rst_n = 1'b1;
        tick();

        // Single word from requester 0
        req            = 4'b0001;
        req_data[31:0] = 32'h4433_2211;
        tick();
        chk("t1_gnt",        64'(gnt),          64'h1);
        chk("t1_wr_en",      64'(fifo_wr_en),   64'h1);
        chk("t1_wr_data",    64'(fifo_wr_data), 64'h4433_2211);
        chk("t1_cv_early",   64'(cons_valid),   64'h0);
        req = '0;
        tick();
        chk("t1_gnt_drop",   64'(gnt),          64'h0);
        chk("t1_wr_en_drop", 64'(fifo_wr_en),   64'h0);
        chk("t1_occ",        64'(dut.r_occ),    64'h4);
        chk("t1_cons_valid", 64'(cons_valid),   64'h1);
`ifdef FWFT_ARB_LEVEL_EN
        chk("t6_level4",     64'(level),        64'h4);
        chk("t6_low_wm4",    64'(low_wm),       64'h0);
`endif

        // Drain the word, then keep popping on an empty FIFO
        cons_rd = 1'b1;
        #1;
        chk("pop_rd_en",     64'(fifo_rd_en),   64'h1);
        tick();
        chk("pop_occ3",      64'(dut.r_occ),    64'h3);
`ifdef FWFT_ARB_LEVEL_EN
        chk("t6_level3",     64'(level),        64'h3);
        chk("t6_low_wm3",    64'(low_wm),       64'h0);
`endif
        tick();
        chk("pop_occ2",      64'(dut.r_occ),    64'h2);
`ifdef FWFT_ARB_LEVEL_EN
        chk("t6_level2",     64'(level),        64'h2);
        chk("t6_low_wm2",    64'(low_wm),       64'h1);
`endif
        tick();
        tick();
        chk("t4_occ0",       64'(dut.r_occ),    64'h0);
        chk("t4_cv0",        64'(cons_valid),   64'h0);
        chk("t4_rd_en0",     64'(fifo_rd_en),   64'h0);
        tick();
        chk("t4_occ_hold",   64'(dut.r_occ),    64'h0);
        chk("t4_cv_hold",    64'(cons_valid),   64'h0);
        cons_rd = 1'b0;

        // Reset during a WRITE cycle (rr_ptr is 1, so requester 1 wins)
        req             = 4'b0010;
        req_data[63:32] = 32'hDDCC_BBAA;
        tick();
        chk("t5_gnt",        64'(gnt),          64'h2);
        chk("t5_wr_en",      64'(fifo_wr_en),   64'h1);
        chk("t5_wr_data",    64'(fifo_wr_data), 64'hDDCC_BBAA);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_gnt_async",  64'(gnt),          64'h0);
        chk("t5_wr_en_async",64'(fifo_wr_en),   64'h0);
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_occ",        64'(dut.r_occ),    64'h0);
        chk("t5_rr_ptr",     64'(dut.r_rr_ptr), 64'h0);
        chk("t5_gnt_idle",   64'(gnt),          64'h0);

        // All four requesting, no pops: two grants fill the FIFO, then stall
        req_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        req      = 4'b1111;
        tick();
        chk("t2_gnt0",       64'(gnt),          64'h1);
        chk("t2_data0",      64'(fifo_wr_data), 64'h1111_1111);
        req = 4'b1110;
        tick();
        chk("t2_gap_gnt",    64'(gnt),          64'h0);
        chk("t2_occ4",       64'(dut.r_occ),    64'h4);
        tick();
        chk("t2_gnt1",       64'(gnt),          64'h2);
        chk("t2_data1",      64'(fifo_wr_data), 64'h2222_2222);
        req = 4'b1100;
        tick();
        chk("t2_occ8",       64'(dut.r_occ),    64'h8);
        tick();
        chk("t2_stall_gnt",  64'(gnt),          64'h0);
        tick();
        chk("t2_stall_gnt2", 64'(gnt),          64'h0);
        chk("t2_stall_wr",   64'(fifo_wr_en),   64'h0);
        cons_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_pop_gnt", 64'(gnt),         64'h0);
            chk("t2_pop_occ", 64'(dut.r_occ),   64'(7 - i));
        end
        cons_rd = 1'b0;
        tick();
        chk("t2_gnt2",       64'(gnt),          64'h4);
        chk("t2_data2",      64'(fifo_wr_data), 64'h3333_3333);
        chk("t2_rr_ptr",     64'(dut.r_rr_ptr), 64'h3);

        // Pop held during the WRITE cycle: 4 + 4 - 1
        cons_rd = 1'b1;
        req     = 4'b1000;
        tick();
        chk("t3_occ7",       64'(dut.r_occ),    64'h7);
        chk("t3_gnt_drop",   64'(gnt),          64'h0);
        cons_rd = 1'b0;
        tick();
        chk("t3_no_space",   64'(gnt),          64'h0);
        chk("t3_occ_hold",   64'(dut.r_occ),    64'h7);
        req = '0;
        tick();
        chk("t3_idle_gnt",   64'(gnt),          64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
